// File: rtl/srio_reinit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : srio_reinit_arbiter_if
// Brief    : Requester-side handshake bundle (req/grant/done/fail/status).
// Revision : 1.0 - initial release
// ============================================================================
interface srio_reinit_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               done;
    logic               fail;
    logic               busy;
    logic [2:0]         attempt;

    modport master (
        input  req,
        output grant, done, fail, busy, attempt
    );

    modport slave (
        output req,
        input  grant, done, fail, busy, attempt
    );
endinterface
`default_nettype wire

// File: rtl/srio_reinit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : srio_reinit_arbiter
// Brief    : Round-robin arbiter sequencing SRIO force_reinit with bounded
//            timeouts and retries. Optional idle watchdog: SRIO_REINIT_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module srio_reinit_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT_W = 16,
    parameter int MAX_RETRY = 3,
    parameter int HOLDOFF   = 16
) (
    input  wire logic                 log_clk,
    input  wire logic                 log_rst_n,
    srio_reinit_arbiter_if.master     req_bus,
    input  wire logic [TIMEOUT_W-1:0] timeout_val,
    input  wire logic                 port_initialized,
    output logic                      force_reinit,
    output logic                      wdog_fire
);

    localparam int c_ptr_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_sum_w  = c_ptr_w + 1;
    localparam int c_hold_w = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [c_sum_w-1:0]   c_num_req   = c_sum_w'(NUM_REQ);
    localparam logic [c_ptr_w-1:0]   c_last_idx  = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(HOLDOFF - 1);
    localparam logic [2:0]           c_max_retry = 3'(MAX_RETRY);
    localparam logic [TIMEOUT_W-1:0] c_timer_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_WAIT_UP = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant,    w_grant_nxt;
    logic [2:0]           r_attempt,  w_attempt_nxt;
    logic [TIMEOUT_W-1:0] r_timer,    w_timer_nxt;
    logic [c_hold_w-1:0]  r_hold_cnt, w_hold_nxt;
    logic [c_ptr_w-1:0]   r_rr_ptr,   w_ptr_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_fail,     w_fail_nxt;
    logic                 w_retry;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate so the search starts at r_rr_ptr
    // ------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [c_ptr_w-1:0]   w_rr_off;
    logic [c_sum_w-1:0]   w_rr_sum;
    logic [c_ptr_w-1:0]   w_rr_win;
    logic [c_ptr_w-1:0]   w_rr_nxt;
    logic [NUM_REQ-1:0]   w_rr_onehot;

    assign w_req_dbl = {req_bus.req, req_bus.req};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_rr_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_rr_off = c_ptr_w'(k);
            end
        end
    end

    assign w_rr_sum    = c_sum_w'(r_rr_ptr) + c_sum_w'(w_rr_off);
    assign w_rr_win    = (w_rr_sum >= c_num_req) ? c_ptr_w'(w_rr_sum - c_num_req)
                                                 : c_ptr_w'(w_rr_sum);
    assign w_rr_nxt    = (w_rr_win == c_last_idx) ? '0 : w_rr_win + c_ptr_w'(1);
    assign w_rr_onehot = NUM_REQ'(1) << w_rr_win;

    // ------------------------------------------------------------------
    // Phase timer helpers
    // ------------------------------------------------------------------
    logic                 w_timeout;
    logic [TIMEOUT_W-1:0] w_timer_inc;

    assign w_timeout   = (timeout_val != '0) && (r_timer == timeout_val);
    assign w_timer_inc = (r_timer == c_timer_max) ? r_timer : r_timer + TIMEOUT_W'(1);

    // ------------------------------------------------------------------
    // Idle watchdog
    // ------------------------------------------------------------------
    logic w_wdog_trip;

`ifdef SRIO_REINIT_WATCHDOG_EN
    localparam logic [TIMEOUT_W-1:0] c_wdog_last = c_timer_max - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] r_wdog_cnt;
    logic [TIMEOUT_W-1:0] w_wdog_cnt_nxt;
    logic                 r_wdog_fire;
    logic                 w_wdog_arm;

    assign w_wdog_arm  = (r_state == ST_IDLE) && !(|req_bus.req) && !port_initialized;
    assign w_wdog_trip = w_wdog_arm && (r_wdog_cnt == c_wdog_last);

    always_comb begin
        w_wdog_cnt_nxt = '0;
        if (w_wdog_arm && !w_wdog_trip) begin
            w_wdog_cnt_nxt = r_wdog_cnt + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_wdog_cnt  <= '0;
            r_wdog_fire <= 1'b0;
        end else begin
            r_wdog_cnt  <= w_wdog_cnt_nxt;
            r_wdog_fire <= w_wdog_trip;
        end
    end

    assign wdog_fire = r_wdog_fire;
`else
    assign w_wdog_trip = 1'b0;
    assign wdog_fire   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Service FSM: next-state and next register values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_attempt_nxt = r_attempt;
        w_timer_nxt   = '0;
        w_hold_nxt    = '0;
        w_ptr_nxt     = r_rr_ptr;
        w_done_nxt    = 1'b0;
        w_fail_nxt    = 1'b0;
        w_retry       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_attempt_nxt = '0;
                if (|req_bus.req) begin
                    w_grant_nxt   = w_rr_onehot;
                    w_attempt_nxt = 3'd1;
                    w_ptr_nxt     = w_rr_nxt;
                    w_state_nxt   = ST_ASSERT;
                end else if (w_wdog_trip) begin
                    // Watchdog service runs ungranted and leaves the pointer alone
                    w_grant_nxt   = '0;
                    w_attempt_nxt = 3'd1;
                    w_state_nxt   = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!port_initialized) begin
                    w_state_nxt = ST_WAIT_UP;
                end else if (w_timeout) begin
                    w_retry = 1'b1;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_WAIT_UP: begin
                // Port event is checked first so it beats a coincident timeout
                if (port_initialized) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_timeout) begin
                    w_retry = 1'b1;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_HOLD: begin
                w_grant_nxt = '0;
                if (r_hold_cnt == c_hold_last) begin
                    w_attempt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_hold_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_retry) begin
            if (r_attempt < c_max_retry) begin
                w_attempt_nxt = r_attempt + 3'd1;
                w_state_nxt   = ST_ASSERT;
            end else begin
                w_fail_nxt  = 1'b1;
                w_state_nxt = ST_HOLD;
            end
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_attempt  <= '0;
            r_timer    <= '0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_attempt  <= w_attempt_nxt;
            r_timer    <= w_timer_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_done     <= w_done_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    assign force_reinit    = (r_state == ST_ASSERT);
    assign req_bus.busy    = (r_state != ST_IDLE);
    assign req_bus.grant   = r_grant;
    assign req_bus.attempt = r_attempt;
    assign req_bus.done    = r_done;
    assign req_bus.fail    = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_srio_reinit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_srio_reinit_arbiter
// Brief    : Directed self-checking bench for srio_reinit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srio_reinit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int HOLDOFF = 16;

    logic        log_clk = 1'b0;
    logic        log_rst_n;
    logic [15:0] timeout_val;
    logic        port_init;
    logic        force_reinit;
    logic        wdog_fire;
    logic [3:0]  timeout_val_wd;
    logic        port_wd;
    logic        force_wd;
    logic        wdog_fire_wd;

    int checks   = 0;
    int failures = 0;

    srio_reinit_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    srio_reinit_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_wd ();

    srio_reinit_arbiter #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_W(16), .MAX_RETRY(3), .HOLDOFF(HOLDOFF)
    ) u_dut (
        .log_clk(log_clk), .log_rst_n(log_rst_n), .req_bus(bus),
        .timeout_val(timeout_val), .port_initialized(port_init),
        .force_reinit(force_reinit), .wdog_fire(wdog_fire)
    );

    // Narrow timer instance so the watchdog threshold is 15 cycles
    srio_reinit_arbiter #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_W(4), .MAX_RETRY(3), .HOLDOFF(HOLDOFF)
    ) u_dut_wd (
        .log_clk(log_clk), .log_rst_n(log_rst_n), .req_bus(bus_wd),
        .timeout_val(timeout_val_wd), .port_initialized(port_wd),
        .force_reinit(force_wd), .wdog_fire(wdog_fire_wd)
    );

    always #5 log_clk = ~log_clk;

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b, required 0 within 100 cycles", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        log_rst_n = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (force_reinit !== 1'b0 || wdog_fire !== 1'b0 || bus.grant !== 4'b0 || bus.done !== 1'b0 ||
            bus.fail !== 1'b0 || bus.busy !== 1'b0 || bus.attempt !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: force=%b wdog=%b grant=%b done=%b fail=%b busy=%b attempt=%0d, required all 0",
                     force_reinit, wdog_fire, bus.grant, bus.done, bus.fail, bus.busy, bus.attempt);
        end
        log_rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== 4'b0 || force_wd !== 1'b0 || bus_wd.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b grant=%b wd_force=%b wd_busy=%b, required 0",
                     bus.busy, bus.grant, force_wd, bus_wd.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant [5];
        int gap;
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        timeout_val = 16'd100;
        bus.req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            gap = 0;
            tick();
            gap++;
            while (bus.grant === 4'b0000 && gap < 64) begin
                tick();
                gap++;
            end
            checks++;
            if (bus.grant !== exp_grant[s]) begin
                failures++;
                $display("FAIL rr_grant[%0d]: grant=%b, required %b", s, bus.grant, exp_grant[s]);
            end
            if (s > 0) begin
                checks++;
                if (gap != HOLDOFF + 1) begin
                    failures++;
                    $display("FAIL rr_gap[%0d]: done-to-grant=%0d cycles, required %0d", s, gap, HOLDOFF + 1);
                end
            end
            port_init = 1'b0;
            tick();
            port_init = 1'b1;
            tick();
            checks++;
            if (bus.done !== 1'b1 || bus.grant !== exp_grant[s]) begin
                failures++;
                $display("FAIL rr_done[%0d]: done=%b grant=%b, required 1 %b", s, bus.done, bus.grant, exp_grant[s]);
            end
            if (s == 4) bus.req = 4'b0000;
        end
        wait_idle("rr");
    endtask

    task automatic test_single();
        timeout_val = 16'd100;
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001 || force_reinit !== 1'b1 || bus.attempt !== 3'd1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start: grant=%b force=%b attempt=%0d busy=%b, required 0001 1 1 1",
                     bus.grant, force_reinit, bus.attempt, bus.busy);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (force_reinit !== 1'b1 || bus.grant !== 4'b0001) begin
                failures++;
                $display("FAIL single_force_hi[%0d]: force=%b grant=%b, required 1 0001", i, force_reinit, bus.grant);
            end
        end
        port_init = 1'b0;
        tick();
        checks++;
        if (force_reinit !== 1'b0 || bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_force_lo: force=%b grant=%b busy=%b, required 0 0001 1",
                     force_reinit, bus.grant, bus.busy);
        end
        for (int i = 0; i < 19; i++) begin
            tick();
            checks++;
            if (bus.grant !== 4'b0001 || bus.done !== 1'b0 || force_reinit !== 1'b0) begin
                failures++;
                $display("FAIL single_wait[%0d]: grant=%b done=%b force=%b, required 0001 0 0",
                         i, bus.grant, bus.done, force_reinit);
            end
        end
        port_init = 1'b1;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.grant !== 4'b0001 || bus.attempt !== 3'd1 || bus.fail !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b grant=%b attempt=%0d fail=%b, required 1 0001 1 0",
                     bus.done, bus.grant, bus.attempt, bus.fail);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: done=%b grant=%b busy=%b, required 0 0000 1", bus.done, bus.grant, bus.busy);
        end
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_hold_end: busy=%b one cycle before holdoff end, required 1", bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.attempt !== 3'd0) begin
            failures++;
            $display("FAIL single_idle: busy=%b attempt=%0d, required 0 0", bus.busy, bus.attempt);
        end
    endtask

    task automatic test_retry();
        logic [2:0] exp_att;
        timeout_val = 16'd10;
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.grant !== 4'b0010 || bus.attempt !== 3'd1) begin
            failures++;
            $display("FAIL retry_start: grant=%b attempt=%0d, required 0010 1", bus.grant, bus.attempt);
        end
        for (int i = 1; i <= 34; i++) begin
            tick();
            exp_att = (i < 11) ? 3'd1 : (i < 22) ? 3'd2 : 3'd3;
            if (i <= 32) begin
                checks++;
                if (force_reinit !== 1'b1 || bus.attempt !== exp_att || bus.fail !== 1'b0 || bus.grant !== 4'b0010) begin
                    failures++;
                    $display("FAIL retry_cycle[%0d]: force=%b attempt=%0d fail=%b grant=%b, required 1 %0d 0 0010",
                             i, force_reinit, bus.attempt, bus.fail, bus.grant, exp_att);
                end
            end else if (i == 33) begin
                checks++;
                if (bus.fail !== 1'b1 || bus.done !== 1'b0 || bus.grant !== 4'b0010 || force_reinit !== 1'b0) begin
                    failures++;
                    $display("FAIL retry_fail: fail=%b done=%b grant=%b force=%b, required 1 0 0010 0",
                             bus.fail, bus.done, bus.grant, force_reinit);
                end
                bus.req = 4'b0000;
            end else begin
                checks++;
                if (bus.fail !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL retry_after: fail=%b grant=%b busy=%b, required 0 0000 1", bus.fail, bus.grant, bus.busy);
                end
            end
        end
        wait_idle("retry");
    endtask

    task automatic test_simultaneous();
        timeout_val = 16'd10;
        bus.req = 4'b0001;
        tick();
        port_init = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (force_reinit !== 1'b0 || bus.attempt !== 3'd1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL sim_pre: force=%b attempt=%0d done=%b, required 0 1 0", force_reinit, bus.attempt, bus.done);
        end
        port_init = 1'b1;
        tick();
        checks++;
        if (bus.done !== 1'b1 || force_reinit !== 1'b0 || bus.attempt !== 3'd1 || bus.grant !== 4'b0001) begin
            failures++;
            $display("FAIL sim_done: done=%b force=%b attempt=%0d grant=%b, required 1 0 1 0001",
                     bus.done, force_reinit, bus.attempt, bus.grant);
        end
        bus.req = 4'b0000;
        timeout_val = 16'd100;
        wait_idle("sim");
    endtask

    task automatic test_reset_mid_service();
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.grant !== 4'b0100) begin
            failures++;
            $display("FAIL rstmid_grant: grant=%b, required 0100", bus.grant);
        end
        port_init = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (force_reinit !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 4'b0100) begin
            failures++;
            $display("FAIL rstmid_waitup: force=%b busy=%b grant=%b, required 0 1 0100", force_reinit, bus.busy, bus.grant);
        end
        log_rst_n = 1'b0;
        #1;
        checks++;
        if (force_reinit !== 1'b0 || wdog_fire !== 1'b0 || bus.grant !== 4'b0 || bus.done !== 1'b0 ||
            bus.fail !== 1'b0 || bus.busy !== 1'b0 || bus.attempt !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_async: force=%b wdog=%b grant=%b done=%b fail=%b busy=%b attempt=%0d, required all 0",
                     force_reinit, wdog_fire, bus.grant, bus.done, bus.fail, bus.busy, bus.attempt);
        end
        bus.req = 4'b0000;
        port_init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet[%0d]: done=%b fail=%b busy=%b, required 0 0 0", i, bus.done, bus.fail, bus.busy);
            end
        end
        log_rst_n = 1'b1;
        tick();
        bus.req = 4'b1001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_ptr: grant=%b, required 0001", bus.grant);
        end
        port_init = 1'b0;
        tick();
        port_init = 1'b1;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.grant !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_done: done=%b grant=%b, required 1 0001", bus.done, bus.grant);
        end
        bus.req = 4'b0000;
        wait_idle("rstmid");
    endtask

    task automatic test_watchdog();
        int n;
        port_wd = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (wdog_fire_wd !== 1'b0 || force_wd !== 1'b0 || bus_wd.busy !== 1'b0) begin
                failures++;
                $display("FAIL wdog_early[%0d]: wdog=%b force=%b busy=%b, required 0 0 0", i, wdog_fire_wd, force_wd, bus_wd.busy);
            end
        end
        tick();
`ifdef SRIO_REINIT_WATCHDOG_EN
        checks++;
        if (wdog_fire_wd !== 1'b1 || force_wd !== 1'b1 || bus_wd.grant !== 4'b0 || bus_wd.attempt !== 3'd1) begin
            failures++;
            $display("FAIL wdog_fire: wdog=%b force=%b grant=%b attempt=%0d, required 1 1 0000 1",
                     wdog_fire_wd, force_wd, bus_wd.grant, bus_wd.attempt);
        end
        tick();
        checks++;
        if (wdog_fire_wd !== 1'b0 || force_wd !== 1'b0 || bus_wd.busy !== 1'b1) begin
            failures++;
            $display("FAIL wdog_pulse: wdog=%b force=%b busy=%b, required 0 0 1", wdog_fire_wd, force_wd, bus_wd.busy);
        end
        port_wd = 1'b1;
        tick();
        checks++;
        if (bus_wd.done !== 1'b1 || bus_wd.grant !== 4'b0) begin
            failures++;
            $display("FAIL wdog_done: done=%b grant=%b, required 1 0000", bus_wd.done, bus_wd.grant);
        end
        n = 0;
        while (bus_wd.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus_wd.busy !== 1'b0) begin
            failures++;
            $display("FAIL wdog_idle: busy=%b, required 0 within 100 cycles", bus_wd.busy);
        end
`else
        checks++;
        if (wdog_fire_wd !== 1'b0 || force_wd !== 1'b0 || bus_wd.busy !== 1'b0) begin
            failures++;
            $display("FAIL wdog_off: wdog=%b force=%b busy=%b, required 0 0 0", wdog_fire_wd, force_wd, bus_wd.busy);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (wdog_fire_wd !== 1'b0 || force_wd !== 1'b0 || bus_wd.busy !== 1'b0) begin
            failures++;
            $display("FAIL wdog_off_late: wdog=%b force=%b busy=%b, required 0 0 0", wdog_fire_wd, force_wd, bus_wd.busy);
        end
        port_wd = 1'b1;
`endif
    endtask

    initial begin
        log_rst_n      = 1'b0;
        timeout_val    = 16'd100;
        port_init      = 1'b1;
        bus.req        = 4'b0000;
        timeout_val_wd = 4'd0;
        port_wd        = 1'b1;
        bus_wd.req     = 4'b0000;

        test_reset();
        test_round_robin();
        test_single();
        test_retry();
        test_simultaneous();
        test_reset_mid_service();
        test_watchdog();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srio_reinit_arbiter.md
# srio_reinit_arbiter

Arbitrates link-reinitialization requests from several user-side requesters and sequences the single `force_reinit` input of the SRIO reset controller. The block runs in the LOG clock domain and sits between the requesters and the reset controller. It performs a bounded-time reinit handshake with the port: it asserts the request, waits for `port_initialized` to fall, releases, then waits for `port_initialized` to rise. Each attempt is retried up to a limit, and every request ends with a per-requester done or fail report.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_W`, 16: width of the phase timer and `timeout_val`.
- `MAX_RETRY`, 3: number of attempts before fail, 1..7.
- `HOLDOFF`, 16: minimum idle cycles between services, ≥1.
- `log_clk  in  1`: single clock. All I/O is synchronous to it, including `port_initialized`.
- `log_rst_n  in  1`: asynchronous, active-low reset.
- `req  in  NUM_REQ`: level request, held until that requester's done/fail.
- `timeout_val  in  TIMEOUT_W`: per-phase timeout in cycles. 0 disables the timeout (wait forever). Quasi-static.
- `port_initialized  in  1`: port status from the PHY.
- `force_reinit  out  1`: drives the reset controller's force_reinit input.
- `grant  out  NUM_REQ`: one-hot or zero; high for the whole service.
- `done  out  1`: 1-cycle pulse; service succeeded. Qualified by `grant`.
- `fail  out  1`: 1-cycle pulse; retries exhausted. Qualified by `grant`.
- `busy  out  1`: high in any state other than IDLE.
- `attempt  out  3`: current attempt number, 1-based; 0 in IDLE.
- `wdog_fire  out  1`: 1-cycle pulse when the watchdog starts a service.

## Operation
- States: IDLE, ASSERT, WAIT_UP, HOLD.
- IDLE:
  - If any `req` bit is set, pick a winner round-robin, starting at the index after the last winner (reset pointer: index 0 first).
  - Register `grant`, set `attempt`=1, clear the timer, go to ASSERT.
- ASSERT:
  - `force_reinit`=1.
  - `port_initialized`==0 → clear the timer, go to WAIT_UP.
  - Timer reaches `timeout_val` (≠0) → retry.
- WAIT_UP:
  - `force_reinit`=0.
  - `port_initialized`==1 → pulse `done`, go to HOLD.
  - Timer reaches `timeout_val` (≠0) → retry.
- Retry:
  - If `attempt`<`MAX_RETRY`: increment `attempt`, clear the timer, go to ASSERT.
  - Otherwise: pulse `fail`, go to HOLD.
- HOLD:
  - `force_reinit`=0.
  - `grant` is cleared on entry.
  - Count `HOLDOFF` cycles, then go to IDLE.
- The timer increments every cycle in ASSERT and WAIT_UP. It saturates at all-ones and never wraps.
- A requester that drops `req` mid-service does not abort the service; done/fail is still pulsed with its `grant`.
- New requests that arrive while `busy` wait. No request is lost, because requests are level-held.
- `req` bits that are set in the same cycle resolve by the round-robin order only.
- Asynchronous reset mid-service: all outputs go to 0 immediately, state returns to IDLE, and the pointer returns to 0. No done/fail is issued.

## Timing
- Reset value of every output is 0.
- A `req` sampled in IDLE at edge N gives `grant` and `force_reinit` high after edge N (1-cycle latency).
- `port_initialized` low sampled at edge M: `force_reinit` low after edge M.
- `port_initialized` high sampled in WAIT_UP at edge K: `done` is high for the cycle after K; `grant` is low from K+1.
- `fail` is issued in the cycle after the timeout edge; `grant` is low from the next cycle.
- Timeout: the phase exits at the edge where the timer equals `timeout_val`, i.e. `timeout_val`+1 cycles after phase entry.
- `port_initialized` edge and timeout in the same cycle: the port event wins (no retry).
- The next `grant` is no earlier than `HOLDOFF`+1 cycles after done/fail.

## Configuration
- `SRIO_REINIT_WATCHDOG_EN` defined: adds a watchdog.
  - In IDLE, with no `req` set, `port_initialized` low for 2^`TIMEOUT_W`−1 consecutive cycles pulses `wdog_fire` and enters ASSERT with `grant`=0.
  - The watchdog service is a normal service: done/fail pulse with `grant`=0.
  - The round-robin pointer is unchanged by a watchdog service.
  - The watchdog counter clears whenever `port_initialized` is high or the block is not in IDLE.
- Undefined: no watchdog logic; `wdog_fire` is tied to 0.

## Test plan
- Single request, nominal: `req`=0001, port falls 5 cycles after `force_reinit` and rises 20 cycles later, `timeout_val`=100.
  - Expect `grant`=0001 for the whole service and `force_reinit` high for 6 cycles.
  - Expect `done` pulse, `attempt`=1, and `busy` low `HOLDOFF` cycles after done.
- Round-robin: `req`=1111 held, with a nominal port model.
  - Expect grants in order 0001, 0010, 0100, 1000, 0001.
  - Expect ≥`HOLDOFF`+1 cycles between grants.
- Timeout/retry: port never falls, `timeout_val`=10, `MAX_RETRY`=3.
  - Expect `attempt` to go 1→2→3.
  - Expect `fail` pulse 33 cycles after grant, with `force_reinit` held high throughout.
- Simultaneous event: port rises in the same cycle the WAIT_UP timer hits `timeout_val`.
  - Expect `done`, not a retry.
- Reset mid-service: `log_rst_n` low during WAIT_UP.
  - Expect all outputs 0 immediately and no done/fail.
  - After release, `req`=1000 and 0001 together → expect grant to 0001 (pointer reset).
- Watchdog (macro on, `TIMEOUT_W`=4): port low for 15 idle cycles with no req.
  - Expect `wdog_fire`, `force_reinit`=1, `grant`=0.
  - With the macro off, expect no action.
